// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ----------------
// Pipeline register between decode and execute with operand forwarding and
// load-use hazard detection.
//
// Each cycle the decode slot is either captured into the execute-stage
// registers or replaced by a bubble. A bubble is inserted on a branch flush,
// on a load-use stall, or when decode holds no instruction.
//
// Both source operands are resolved with this priority:
//   EX producer > MEM producer > WB producer > register-file data.
// Index 0 always resolves to zero.
//
// Ports
//   clk, reset (async, active-high)
//   id_*               decode-slot instruction fields
//   ex_alu_result_i    ALU result of the instruction currently held here
//   mem_* / wb_*       downstream producers used for forwarding
//   flush_i            squash the decode-slot instruction
//   ex_* / a_o / b_o / store_data_o / alu_operation_o   registered outputs
//   stall_o            combinational load-use stall request to decode
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic        id_alu_src_i,
  input  logic        id_uses_rs2_i,
  input  logic [3:0]  id_alu_op_i,
  input  logic        id_reg_write_i,
  input  logic        id_mem_read_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic        mem_reg_write_i,
  input  logic [31:0] mem_result_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        wb_reg_write_i,
  input  logic [31:0] wb_result_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  output logic [3:0]  alu_operation_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  ex_rd_addr_o,
  output logic        ex_reg_write_o,
  output logic        ex_mem_read_o,
  output logic        stall_o
);

  logic        ex_valid_q,      ex_valid_d;
  logic [3:0]  alu_operation_q, alu_operation_d;
  logic [31:0] a_q,             a_d;
  logic [31:0] b_q,             b_d;
  logic [31:0] store_data_q,    store_data_d;
  logic [4:0]  ex_rd_addr_q,    ex_rd_addr_d;
  logic        ex_reg_write_q,  ex_reg_write_d;
  logic        ex_mem_read_q,   ex_mem_read_d;

  // A load in EX has no result yet, so it is never a forwarding source; it
  // is handled by the stall logic instead.
  logic ex_fwd_en;
  logic mem_fwd_en;
  logic wb_fwd_en;

  assign ex_fwd_en  = ex_valid_q && ex_reg_write_q && !ex_mem_read_q &&
                      (ex_rd_addr_q != 5'd0);
  assign mem_fwd_en = mem_reg_write_i && (mem_rd_addr_i != 5'd0);
  assign wb_fwd_en  = wb_reg_write_i && (wb_rd_addr_i != 5'd0);

  // Operand 0 is rs1 and operand 1 is rs2.
  logic [1:0][4:0]  rs_addr;
  logic [1:0][31:0] rs_data;
  logic [1:0][31:0] rs_fwd;

  assign rs_addr = {id_rs2_addr_i, id_rs1_addr_i};
  assign rs_data = {id_rs2_data_i, id_rs1_data_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign rs_fwd[gi] =
        (rs_addr[gi] == 5'd0)                                ? 32'h0 :
        (ex_fwd_en  && (ex_rd_addr_q  == rs_addr[gi]))       ? ex_alu_result_i :
        (mem_fwd_en && (mem_rd_addr_i == rs_addr[gi]))       ? mem_result_i :
        (wb_fwd_en  && (wb_rd_addr_i  == rs_addr[gi]))       ? wb_result_i :
                                                               rs_data[gi];
    end
  endgenerate

  // Load-use hazard: decode needs a register that the load in EX has not yet
  // fetched. The bubble inserted here clears ex_mem_read, so the stall
  // releases after one cycle and the load result arrives through MEM
  // forwarding. A flush overrides the stall.
  logic load_use;

  always_comb begin
    load_use = id_valid_i && ex_valid_q && ex_mem_read_q &&
               (ex_rd_addr_q != 5'd0) &&
               ((ex_rd_addr_q == id_rs1_addr_i) ||
                (id_uses_rs2_i && (ex_rd_addr_q == id_rs2_addr_i)));
    stall_o  = load_use && !flush_i && !reset;
  end

  always_comb begin
    ex_valid_d      = 1'b0;
    alu_operation_d = 4'd0;
    a_d             = 32'h0;
    b_d             = 32'h0;
    store_data_d    = 32'h0;
    ex_rd_addr_d    = 5'd0;
    ex_reg_write_d  = 1'b0;
    ex_mem_read_d   = 1'b0;
    if (id_valid_i && !flush_i && !load_use) begin
      ex_valid_d      = 1'b1;
      alu_operation_d = id_alu_op_i;
      a_d             = rs_fwd[0];
      b_d             = id_alu_src_i ? id_imm_i : rs_fwd[1];
      store_data_d    = rs_fwd[1];
      ex_rd_addr_d    = id_rd_addr_i;
      ex_reg_write_d  = id_reg_write_i;
      ex_mem_read_d   = id_mem_read_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q      <= 1'b0;
      alu_operation_q <= 4'd0;
      a_q             <= 32'h0;
      b_q             <= 32'h0;
      store_data_q    <= 32'h0;
      ex_rd_addr_q    <= 5'd0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      alu_operation_q <= alu_operation_d;
      a_q             <= a_d;
      b_q             <= b_d;
      store_data_q    <= store_data_d;
      ex_rd_addr_q    <= ex_rd_addr_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
    end
  end

  assign ex_valid_o      = ex_valid_q;
  assign alu_operation_o = alu_operation_q;
  assign a_o             = a_q;
  assign b_o             = b_q;
  assign store_data_o    = store_data_q;
  assign ex_rd_addr_o    = ex_rd_addr_q;
  assign ex_reg_write_o  = ex_reg_write_q;
  assign ex_mem_read_o   = ex_mem_read_q;

endmodule
